// File: rtl/cdf_write_back.sv
// cdf_write_back: streams a histogram out of a 1-cycle-latency memory and
// writes its running sum (the CDF) into a second memory.
// The accumulator saturates, and saturation is flagged on a sticky overflow.
// cdf_min records the first nonzero CDF value of the run.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the results of the last run
// RUN   | issuing histogram reads, one address per cycle
// DRAIN | read pipeline emptying; last CDF writes still in flight
// DONE  | done pulse cycle; start ignored, then back to IDLE
module cdf_write_back #(
    parameter int NUM_BINS = 256,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              hist_rd_en,
    output logic [ADDR_W-1:0] hist_rd_addr,
    input  logic [DATA_W-1:0] hist_rd_data,
    output logic              cdf_wr_en,
    output logic [ADDR_W-1:0] cdf_wr_addr,
    output logic [DATA_W-1:0] cdf_wr_data,
    output logic [DATA_W-1:0] cdf_min,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
    localparam logic [DATA_W-1:0] SAT_MAX   = '1;

    state_t            state;
    logic [DATA_W-1:0] acc;
    // rd_pend marks that hist_rd_data carries the bin addressed at pend_addr
    logic              rd_pend;
    logic [ADDR_W-1:0] pend_addr;

    logic [DATA_W:0]   sum_wide;
    logic              sum_sat;
    logic [DATA_W-1:0] acc_next;

    // Saturating add of the incoming histogram count to the running sum
    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, hist_rd_data};
        sum_sat  = sum_wide[DATA_W];
        acc_next = sum_sat ? SAT_MAX : sum_wide[DATA_W-1:0];
    end

    // Sequencer, read-data pipeline and CDF write path
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            hist_rd_en   <= 1'b0;
            hist_rd_addr <= '0;
            cdf_wr_en    <= 1'b0;
            cdf_wr_addr  <= '0;
            cdf_wr_data  <= '0;
            cdf_min      <= '0;
            overflow     <= 1'b0;
            acc          <= '0;
            rd_pend      <= 1'b0;
            pend_addr    <= '0;
        end else begin
            rd_pend   <= hist_rd_en;
            pend_addr <= hist_rd_addr;
            cdf_wr_en <= 1'b0;
            done      <= 1'b0;

            if (rd_pend) begin
                acc         <= acc_next;
                cdf_wr_en   <= 1'b1;
                cdf_wr_addr <= pend_addr;
                cdf_wr_data <= acc_next;
                if (sum_sat) begin
                    overflow <= 1'b1;
                end
                if ((cdf_min == '0) && (acc_next != '0)) begin
                    cdf_min <= acc_next;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        hist_rd_en   <= 1'b1;
                        hist_rd_addr <= '0;
                        acc          <= '0;
                        cdf_min      <= '0;
                        overflow     <= 1'b0;
                    end
                end
                RUN: begin
                    // address counter stops on the last bin, so it never
                    // walks past NUM_BINS-1 even when 2^ADDR_W is larger
                    if (hist_rd_addr == LAST_ADDR) begin
                        hist_rd_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        hist_rd_addr <= hist_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // once no read is pending, the final write has already gone out
                    if (!rd_pend) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdf_write_back.sv
// Testbench for cdf_write_back: histogram memory model, write/done monitor
// and a prefix-sum reference model with saturation.
module tb_cdf_write_back;

    localparam int NB = 256;
    localparam int AW = 8;
    localparam int DW = 20;
    localparam longint MAXV = (longint'(1) << DW) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          hist_rd_en;
    logic [AW-1:0] hist_rd_addr;
    logic [DW-1:0] hist_rd_data;
    logic          cdf_wr_en;
    logic [AW-1:0] cdf_wr_addr;
    logic [DW-1:0] cdf_wr_data;
    logic [DW-1:0] cdf_min;
    logic          overflow;

    cdf_write_back #(.NUM_BINS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .hist_rd_en   (hist_rd_en),
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data),
        .cdf_wr_en    (cdf_wr_en),
        .cdf_wr_addr  (cdf_wr_addr),
        .cdf_wr_data  (cdf_wr_data),
        .cdf_min      (cdf_min),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] hist [NB];

    // histogram memory: 1-cycle synchronous read
    always @(posedge clock) begin
        if (hist_rd_en) hist_rd_data <= hist[hist_rd_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int            wr_cnt, done_cnt, first_wr_cyc, last_wr_cyc, done_cyc, start_cyc;
    logic [AW-1:0] got_addr [512];
    logic [DW-1:0] got_data [512];
    logic          got_ovf  [512];
    logic [DW-1:0] done_min;
    logic          done_ovf;

    // monitor: record every CDF write and done pulse away from the clock edge
    always @(negedge clock) begin
        if (cdf_wr_en) begin
            if (wr_cnt == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            if (wr_cnt < 512) begin
                got_addr[wr_cnt] = cdf_wr_addr;
                got_data[wr_cnt] = cdf_wr_data;
                got_ovf[wr_cnt]  = overflow;
            end
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_min = cdf_min;
            done_ovf = overflow;
        end
    end

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_cdf [NB];
    logic          exp_ovf [NB];
    logic [DW-1:0] exp_min;

    // reference: saturating prefix sum of the histogram
    task automatic build_model();
        longint s = 0;
        bit sat = 0;
        exp_min = '0;
        for (int i = 0; i < NB; i++) begin
            s = s + longint'(hist[i]);
            if (s > MAXV) begin
                s = MAXV;
                sat = 1;
            end
            exp_cdf[i] = s[DW-1:0];
            exp_ovf[i] = sat;
            if (exp_min == '0 && s != 0) exp_min = s[DW-1:0];
        end
    endtask

    // pulse start, then wait (bounded) for done; extra start pulses at offsets p0..p2
    task automatic do_run(input bit skip_neg, input int p0, input int p1, input int p2,
                          output bit to);
        wr_cnt   = 0;
        done_cnt = 0;
        if (!skip_neg) @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        to = 1'b1;
        for (int j = 1; j < 400; j++) begin
            @(negedge clock);
            start = (j == p0) || (j == p1) || (j == p2);
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        if (to) start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        hist_rd_data = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, hist_rd_en, hist_rd_addr, cdf_wr_en, cdf_wr_addr, cdf_wr_data,
             cdf_min, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b wr_en=%b data=%h min=%h ovf=%b, all must be 0",
                     busy, done, hist_rd_en, cdf_wr_en, cdf_wr_data, cdf_min, overflow);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if (busy !== 1'b0 || hist_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b rd_en=%b, required 0 0", busy, hist_rd_en);
        end
    endtask

    task automatic test_all_ones();
        bit to;
        for (int i = 0; i < NB; i++) hist[i] = 1;
        build_model();
        do_run(1'b0, -1, -1, -1, to);
        total++;
        if (to) begin bad++; $display("FAIL all_ones_timeout: no done within budget"); end
        total++;
        if (wr_cnt !== NB) begin bad++; $display("FAIL all_ones_count: got %0d writes, need %0d", wr_cnt, NB); end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== DW'(i + 1)) begin
                bad++;
                $display("FAIL all_ones_write[%0d]: addr=%0d data=%0d, need addr=%0d data=%0d",
                         i, got_addr[i], got_data[i], i, i + 1);
            end
        end
        total++;
        if (done_cyc - start_cyc !== 258) begin
            bad++; $display("FAIL all_ones_done_latency: %0d cycles, need 258", done_cyc - start_cyc);
        end
        total++;
        if (first_wr_cyc - start_cyc !== 2 || last_wr_cyc - first_wr_cyc !== NB - 1) begin
            bad++;
            $display("FAIL all_ones_write_window: first at +%0d span %0d, need +2 span %0d",
                     first_wr_cyc - start_cyc, last_wr_cyc - first_wr_cyc, NB - 1);
        end
        total++;
        if (done_min !== 20'd1 || done_ovf !== 1'b0) begin
            bad++; $display("FAIL all_ones_min_ovf: min=%0d ovf=%b, need 1 0", done_min, done_ovf);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL all_ones_busy: busy=%b at done, need 0", busy); end
    endtask

    task automatic test_leading_zeros();
        bit to;
        for (int i = 0; i < NB; i++) hist[i] = (i < 10) ? 20'd0 : 20'd5;
        build_model();
        do_run(1'b0, -1, -1, -1, to);
        total++;
        if (to || wr_cnt !== NB) begin
            bad++; $display("FAIL zeros_run: timeout=%b writes=%0d, need 0 %0d", to, wr_cnt, NB);
        end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== exp_cdf[i]) begin
                bad++;
                $display("FAIL zeros_write[%0d]: addr=%0d data=%0d, need addr=%0d data=%0d",
                         i, got_addr[i], got_data[i], i, exp_cdf[i]);
            end
        end
        total++;
        if (got_data[9] !== 20'd0 || got_data[10] !== 20'd5 || got_data[255] !== 20'd1230) begin
            bad++;
            $display("FAIL zeros_points: cdf9=%0d cdf10=%0d cdf255=%0d, need 0 5 1230",
                     got_data[9], got_data[10], got_data[255]);
        end
        total++;
        if (done_min !== 20'd5 || done_ovf !== 1'b0) begin
            bad++; $display("FAIL zeros_min_ovf: min=%0d ovf=%b, need 5 0", done_min, done_ovf);
        end
    endtask

    task automatic test_saturation();
        bit to;
        for (int i = 0; i < NB; i++) hist[i] = '0;
        hist[0] = 20'hFFFFF;
        hist[1] = 20'd1;
        build_model();
        do_run(1'b0, -1, -1, -1, to);
        total++;
        if (to || wr_cnt !== NB) begin
            bad++; $display("FAIL sat_run: timeout=%b writes=%0d, need 0 %0d", to, wr_cnt, NB);
        end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_data[i] !== 20'hFFFFF || got_ovf[i] !== exp_ovf[i]) begin
                bad++;
                $display("FAIL sat_write[%0d]: data=%h ovf=%b, need data=fffff ovf=%b",
                         i, got_data[i], got_ovf[i], exp_ovf[i]);
            end
        end
        total++;
        if (got_ovf[0] !== 1'b0 || got_ovf[1] !== 1'b1) begin
            bad++; $display("FAIL sat_ovf_timing: ovf@0=%b ovf@1=%b, need 0 1", got_ovf[0], got_ovf[1]);
        end
        total++;
        if (done_min !== 20'hFFFFF || done_ovf !== 1'b1) begin
            bad++; $display("FAIL sat_min_ovf: min=%h ovf=%b, need fffff 1", done_min, done_ovf);
        end
    endtask

    task automatic test_random(input int big);
        bit to;
        for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 3) == 0) hist[i] = '0;
            else if (big != 0) hist[i] = DW'($urandom_range(0, 20'h1FFFF));
            else hist[i] = DW'($urandom_range(0, 3000));
        end
        build_model();
        do_run(1'b0, -1, -1, -1, to);
        total++;
        if (to || wr_cnt !== NB) begin
            bad++; $display("FAIL rand%0d_run: timeout=%b writes=%0d, need 0 %0d", big, to, wr_cnt, NB);
        end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== exp_cdf[i] || got_ovf[i] !== exp_ovf[i]) begin
                bad++;
                $display("FAIL rand%0d_write[%0d]: addr=%0d data=%0d ovf=%b, need %0d %0d %b",
                         big, i, got_addr[i], got_data[i], got_ovf[i], i, exp_cdf[i], exp_ovf[i]);
            end
        end
        total++;
        if (done_min !== exp_min || done_ovf !== exp_ovf[NB-1]) begin
            bad++;
            $display("FAIL rand%0d_min_ovf: min=%0d ovf=%b, need %0d %b",
                     big, done_min, done_ovf, exp_min, exp_ovf[NB-1]);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        for (int i = 0; i < NB; i++) hist[i] = DW'($urandom_range(0, 100));
        build_model();
        do_run(1'b0, 5, 100, 257, to);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        total++;
        if (to || done_cnt !== 1) begin
            bad++; $display("FAIL ignore_done_pulses: timeout=%b pulses=%0d, need 0 1", to, done_cnt);
        end
        total++;
        if (wr_cnt !== NB) begin bad++; $display("FAIL ignore_count: got %0d writes, need %0d", wr_cnt, NB); end
        total++;
        if (done_cyc - start_cyc !== 258) begin
            bad++; $display("FAIL ignore_latency: %0d cycles, need 258", done_cyc - start_cyc);
        end
        total++;
        if (busy !== 1'b0 || hist_rd_en !== 1'b0) begin
            bad++; $display("FAIL ignore_idle: busy=%b rd_en=%b, need 0 0", busy, hist_rd_en);
        end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_data[i] !== exp_cdf[i]) begin
                bad++; $display("FAIL ignore_write[%0d]: data=%0d, need %0d", i, got_data[i], exp_cdf[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        int n;
        for (int i = 0; i < NB; i++) hist[i] = 1;
        wr_cnt   = 0;
        done_cnt = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            #1;
            if (wr_cnt >= 100) begin
                to = 1'b0;
                break;
            end
        end
        total++;
        if (to) begin bad++; $display("FAIL midrst_reach: only %0d writes seen, need 100", wr_cnt); end
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, hist_rd_en, hist_rd_addr, cdf_wr_en, cdf_wr_addr, cdf_wr_data,
             cdf_min, overflow} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: busy=%b rd_en=%b wr_en=%b data=%0d min=%0d, all must be 0",
                     busy, hist_rd_en, cdf_wr_en, cdf_wr_data, cdf_min);
        end
        n = wr_cnt;
        repeat (5) @(negedge clock);
        #1;
        total++;
        if (wr_cnt !== n || done_cnt !== 0) begin
            bad++; $display("FAIL midrst_no_writes: writes %0d->%0d done=%0d, need no change", n, wr_cnt, done_cnt);
        end
        reset_n = 1'b1;
        build_model();
        do_run(1'b1, -1, -1, -1, to);
        total++;
        if (to || wr_cnt !== NB || done_cyc - start_cyc !== 258) begin
            bad++;
            $display("FAIL midrst_rerun: timeout=%b writes=%0d latency=%0d, need 0 %0d 258",
                     to, wr_cnt, done_cyc - start_cyc, NB);
        end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_addr[i] !== AW'(i) || got_data[i] !== exp_cdf[i]) begin
                bad++;
                $display("FAIL midrst_write[%0d]: addr=%0d data=%0d, need %0d %0d",
                         i, got_addr[i], got_data[i], i, exp_cdf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        for (int i = 0; i < NB; i++) hist[i] = '0;
        hist[3] = 20'hFFFF0;
        hist[4] = 20'h00100;
        do_run(1'b0, -1, -1, -1, to);
        total++;
        if (to || done_ovf !== 1'b1 || done_min !== 20'hFFFF0) begin
            bad++;
            $display("FAIL b2b_first: timeout=%b ovf=%b min=%h, need 0 1 ffff0", to, done_ovf, done_min);
        end
        for (int i = 0; i < NB; i++) hist[i] = '0;
        build_model();
        do_run(1'b0, -1, -1, -1, to);
        total++;
        if (to || wr_cnt !== NB || done_cyc - start_cyc !== 258) begin
            bad++;
            $display("FAIL b2b_second: timeout=%b writes=%0d latency=%0d, need 0 %0d 258",
                     to, wr_cnt, done_cyc - start_cyc, NB);
        end
        for (int i = 0; i < NB; i++) begin
            total++;
            if (got_data[i] !== exp_cdf[i]) begin
                bad++; $display("FAIL b2b_write[%0d]: data=%0d, need %0d", i, got_data[i], exp_cdf[i]);
            end
        end
        total++;
        if (done_min !== 20'd0 || done_ovf !== 1'b0) begin
            bad++; $display("FAIL b2b_min_ovf: min=%0d ovf=%b, need 0 0", done_min, done_ovf);
        end
    endtask

    initial begin
        wr_cnt = 0;
        done_cnt = 0;
        test_reset();
        test_all_ones();
        test_leading_zeros();
        test_saturation();
        test_random(0);
        test_random(1);
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
